uart_receiver: RTL

Serial-to-parallel UART receiver; the downstream consumer of the team's UART transmitter line. Recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from an asynchronous `rx` line using mid-bit sampling at `CLKS_PER_BIT` clocks per bit. Holds each received byte in a one-entry output register with a read handshake, and flags framing errors and overruns.

---
 rtl/uart_receiver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling, a one-entry
// output register with read handshake, and framing-error/overrun flags.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       overrun,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_s1;
  logic          r_rx_s;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_overrun;
  logic          r_fe;
  logic          r_busy;
  logic          w_load;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_s1   <= rx;
      r_rx_s <= r_s1;
    end
  end

  // A good stop bit completes the frame and loads the output register.
  always_comb begin
    w_load = 1'b0;
    if ((r_state == S_STOP) && (r_cnt == FULL_M1) && r_rx_s)
      w_load = 1'b1;
  end

  // Receive FSM: start-bit qualification, data shifting, stop check, break hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_fe    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt       <= '0;
            r_sh[r_idx] <= r_rx_s;
            if (r_idx == 3'd7)
              r_state <= S_STOP;
            else
              r_idx <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_fe    <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register handshake: a load always wins over a same-cycle read,
  // and a read in that cycle counts as consuming the previous byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_sh;
      r_valid <= 1'b1;
      if (r_valid && !rd)
        r_overrun <= 1'b1;
      else if (r_valid && rd)
        r_overrun <= 1'b0;
    end else if (rd && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_out      = r_data;
  assign valid         = r_valid;
  assign overrun       = r_overrun;
  assign framing_error = r_fe;
  assign busy          = r_busy;

endmodule
